// File: rtl/conv_pkg.sv
// Shared widths, fixed-point defaults and FSM encoding for the convolution allocator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

    localparam int DATA_W        = 18;
    localparam int PROD_W        = 2 * DATA_W;
    localparam int COORD_W       = 8;
    localparam int DEPTH_W       = 9;
    localparam int WADDR_W       = 14;
    localparam int FRAC_BITS_DEF = 8;

    // Cycles spent in DRAIN so the last beat's product has reached the accumulator.
    localparam int DRAIN_CYC = 3;

    // Output saturation limits of the 18-bit signed result.
    localparam int SAT_MAX_INT = 131071;
    localparam int SAT_MIN_INT = -131072;
    localparam logic [DATA_W-1:0] SAT_MAX = 18'h1FFFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 18'h20000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FULL  = 2'd3
    } state_t;

endpackage

// File: rtl/allocator_mac.sv
// Multiply-accumulate core: product register, clearable accumulator, shift/saturate/ReLU output.
// Latency: product registered one cycle after operands, accumulated the cycle after; output is combinational on acc + pending product.
// Backpressure: none; consumes one operand pair per cycle. ReLU enabled by defining ALLOCATOR_RELU_EN.
module allocator_mac
    import conv_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int ACC_W     = 48
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_vld,
    input  logic [DATA_W-1:0]   i_dat,
    input  logic [DATA_W-1:0]   i_wgt,
    output logic [DATA_W-1:0]   o_result
);

    localparam logic signed [ACC_W-1:0] W_MAX = ACC_W'(SAT_MAX_INT);
    localparam logic signed [ACC_W-1:0] W_MIN = ACC_W'(SAT_MIN_INT);

    logic signed [PROD_W-1:0] w_dat_x;
    logic signed [PROD_W-1:0] w_wgt_x;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] r_prod;
    logic                     r_prod_vld;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_add;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W-1:0]  w_shifted;
    logic [DATA_W-1:0]        w_sat;

    // Sign-extend both operands so the low PROD_W bits of the product are the exact signed result.
    assign w_dat_x    = {{DATA_W{i_dat[DATA_W-1]}}, i_dat};
    assign w_wgt_x    = {{DATA_W{i_wgt[DATA_W-1]}}, i_wgt};
    assign w_prod     = w_dat_x * w_wgt_x;
    assign w_prod_ext = {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
    assign w_add      = r_prod_vld ? w_prod_ext : {ACC_W{1'b0}};
    // The output stage looks at acc plus the pending product, so a beat in the
    // final pipeline slot is still counted when the result is captured.
    assign w_acc_next = r_acc + w_add;
    assign w_shifted  = w_acc_next >>> FRAC_BITS;

    // Product register and accumulator; a clear also drops the product in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else if (i_clr) begin
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_prod_vld <= i_vld;
            if (i_vld) begin
                r_prod <= w_prod;
            end
            r_acc <= w_acc_next;
        end
    end

    // Saturate the shifted sum to 18 bits, optionally clamping negatives to zero.
    always_comb begin
        w_sat = w_shifted[DATA_W-1:0];
        if (w_shifted > W_MAX) begin
            w_sat = SAT_MAX;
        end else if (w_shifted < W_MIN) begin
            w_sat = SAT_MIN;
        end
`ifdef ALLOCATOR_RELU_EN
        if (w_sat[DATA_W-1]) begin
            w_sat = '0;
        end
`endif
    end

    assign o_result = w_sat;

endmodule

// File: rtl/allocator.sv
// Per-DSP convolution allocator: captures a centre, accumulates in-window pixel*weight beats, emits one result pixel.
// Latency: beat -> weight address 1 cycle, accumulate at 3; result_valid 4 cycles after round_done rises.
// Backpressure: issue_block held in DRAIN and while the result waits in FULL; ALLOCATOR_RELU_EN enables ReLU on the result.
module allocator
    import conv_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int ACC_W     = 48
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           filter_halfsize,
    input  logic [DEPTH_W-1:0]   image_depth,
    input  logic [COORD_W-1:0]   positioner_x,
    input  logic [COORD_W-1:0]   positioner_y,
    input  logic                 positioner_select,
    input  logic [COORD_W-1:0]   issue_x,
    input  logic [COORD_W-1:0]   issue_y,
    input  logic [DATA_W-1:0]    issue_data,
    input  logic                 issue_en,
    input  logic                 round_done,
    output logic                 issue_block,
    output logic [WADDR_W-1:0]   weight_read_addr,
    input  logic [DATA_W-1:0]    weight_read_data,
    output logic [DATA_W-1:0]    result_data,
    output logic [COORD_W-1:0]   result_x,
    output logic [COORD_W-1:0]   result_y,
    output logic                 result_valid,
    input  logic                 result_ready
);

    state_t               r_state;
    logic [COORD_W-1:0]   r_cx;
    logic [COORD_W-1:0]   r_cy;
    logic [DEPTH_W-1:0]   r_z;
    logic [COORD_W-1:0]   r_prev_x;
    logic [COORD_W-1:0]   r_prev_y;
    logic                 r_rd_q;
    logic [1:0]           r_drain_cnt;
    logic                 r_s1_vld;
    logic [DATA_W-1:0]    r_s1_dat;
    logic                 r_s2_vld;
    logic [DATA_W-1:0]    r_s2_dat;

    logic                 w_capture;
    logic                 w_beat;
    logic                 w_rd_rise;
    logic                 w_new_pix;
    logic [DEPTH_W-1:0]   w_z_cur;
    logic [DEPTH_W-1:0]   w_z_next;
    logic [8:0]           w_dx;
    logic [8:0]           w_dy;
    logic [8:0]           w_2h;
    logic [2:0]           w_k;
    logic                 w_in_win;
    logic [5:0]           w_tap;
    logic [WADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]    w_result;

    // A select is honoured in IDLE, ARMED, and in FULL only on the handshake cycle.
    assign w_capture = positioner_select &&
                       ((r_state == ST_IDLE) || (r_state == ST_ARMED) ||
                        ((r_state == ST_FULL) && result_ready));
    // The beat that coincides with a re-centre belongs to the old centre and is dropped.
    assign w_beat    = issue_en && (r_state == ST_ARMED) && !positioner_select;
    assign w_rd_rise = round_done && !r_rd_q;

    // Channel index restarts on a new pixel coordinate or after the last channel.
    assign w_new_pix = (issue_x != r_prev_x) || (issue_y != r_prev_y);
    assign w_z_cur   = w_new_pix ? '0 : r_z;
    assign w_z_next  = (w_z_cur == image_depth - 9'd1) ? '0 : w_z_cur + 9'd1;

    // Window offsets in 9-bit two's complement; negative or beyond 2h means outside.
    assign w_dx     = {1'b0, issue_x} - {1'b0, r_cx} + {7'b0, filter_halfsize};
    assign w_dy     = {1'b0, issue_y} - {1'b0, r_cy} + {7'b0, filter_halfsize};
    assign w_2h     = {6'b0, filter_halfsize, 1'b0};
    assign w_k      = {filter_halfsize, 1'b1};
    assign w_in_win = !w_dx[8] && !w_dy[8] && (w_dx <= w_2h) && (w_dy <= w_2h);

    // Filter memory is laid out tap-major, channel-minor.
    assign w_tap  = 6'(w_dy[2:0]) * 6'(w_k) + 6'(w_dx[2:0]);
    assign w_addr = WADDR_W'(w_tap) * WADDR_W'(image_depth) + WADDR_W'(w_z_cur);

    // Pause issue while draining and while an undrained result is held.
    assign issue_block = (r_state == ST_DRAIN) || ((r_state == ST_FULL) && !result_ready);

    // Beat pipeline: channel tracking, weight address issue, data aligned to read latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_q           <= 1'b0;
            r_z              <= '0;
            r_prev_x         <= '0;
            r_prev_y         <= '0;
            r_s1_vld         <= 1'b0;
            r_s1_dat         <= '0;
            r_s2_vld         <= 1'b0;
            r_s2_dat         <= '0;
            weight_read_addr <= '0;
        end else begin
            r_rd_q   <= round_done;
            r_s2_dat <= r_s1_dat;
            if (w_capture) begin
                r_s1_vld <= 1'b0;
                r_s2_vld <= 1'b0;
                r_z      <= '0;
            end else begin
                r_s1_vld <= w_beat && w_in_win;
                r_s2_vld <= r_s1_vld;
                if (w_beat) begin
                    r_z      <= w_z_next;
                    r_prev_x <= issue_x;
                    r_prev_y <= issue_y;
                end
            end
            if (w_beat && w_in_win) begin
                weight_read_addr <= w_addr;
                r_s1_dat         <= issue_data;
            end
        end
    end

    allocator_mac #(
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_capture),
        .i_vld    (r_s2_vld),
        .i_dat    (r_s2_dat),
        .i_wgt    (weight_read_data),
        .o_result (w_result)
    );

    // Round control FSM with registered result port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cx         <= '0;
            r_cy         <= '0;
            r_drain_cnt  <= '0;
            result_data  <= '0;
            result_x     <= '0;
            result_y     <= '0;
            result_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (positioner_select) begin
                        r_cx    <= positioner_x;
                        r_cy    <= positioner_y;
                        r_state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (positioner_select) begin
                        r_cx <= positioner_x;
                        r_cy <= positioner_y;
                    end else if (w_rd_rise) begin
                        r_drain_cnt <= '0;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == 2'(DRAIN_CYC - 1)) begin
                        result_data  <= w_result;
                        result_x     <= r_cx;
                        result_y     <= r_cy;
                        result_valid <= 1'b1;
                        r_state      <= ST_FULL;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                ST_FULL: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        if (positioner_select) begin
                            r_cx    <= positioner_x;
                            r_cy    <= positioner_y;
                            r_state <= ST_ARMED;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_allocator.sv
// Directed bench for allocator: window sums, addressing, saturation, sign handling, hold and reset.
// Latency: checks result_valid exactly 4 cycles after round_done rises.
// Backpressure: holds result_ready low to observe issue_block and an ignored select in FULL.
module tb_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  filter_halfsize;
    logic [8:0]  image_depth;
    logic [7:0]  positioner_x, positioner_y;
    logic        positioner_select;
    logic [7:0]  issue_x, issue_y;
    logic [17:0] issue_data;
    logic        issue_en;
    logic        round_done;
    logic        issue_block;
    logic [13:0] weight_read_addr;
    logic [17:0] weight_read_data;
    logic [17:0] result_data;
    logic [7:0]  result_x, result_y;
    logic        result_valid;
    logic        result_ready;

    logic [17:0] wmem [0:16383];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Filter memory model with one-cycle read latency.
    always @(posedge clk) weight_read_data <= wmem[weight_read_addr];

    allocator dut (
        .clk               (clk),
        .rst               (rst),
        .filter_halfsize   (filter_halfsize),
        .image_depth       (image_depth),
        .positioner_x      (positioner_x),
        .positioner_y      (positioner_y),
        .positioner_select (positioner_select),
        .issue_x           (issue_x),
        .issue_y           (issue_y),
        .issue_data        (issue_data),
        .issue_en          (issue_en),
        .round_done        (round_done),
        .issue_block       (issue_block),
        .weight_read_addr  (weight_read_addr),
        .weight_read_data  (weight_read_data),
        .result_data       (result_data),
        .result_x          (result_x),
        .result_y          (result_y),
        .result_valid      (result_valid),
        .result_ready      (result_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_w(input logic [17:0] v);
        for (int i = 0; i < 16384; i++) wmem[i] = v;
    endtask

    task automatic do_select(input int x, input int y);
        positioner_x      = 8'(x);
        positioner_y      = 8'(y);
        positioner_select = 1'b1;
        tick;
        positioner_select = 1'b0;
    endtask

    task automatic beat(input int x, input int y, input int d);
        issue_x    = 8'(x);
        issue_y    = 8'(y);
        issue_data = 18'(d);
        issue_en   = 1'b1;
        tick;
        issue_en   = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_blk"},   32'(issue_block),      32'd0);
        check({tag, "_vld"},   32'(result_valid),     32'd0);
        check({tag, "_data"},  32'(result_data),      32'd0);
        check({tag, "_rx"},    32'(result_x),         32'd0);
        check({tag, "_ry"},    32'(result_y),         32'd0);
        check({tag, "_waddr"}, 32'(weight_read_addr), 32'd0);
    endtask

    task automatic round_end(input string tag, input logic [31:0] exp_d,
                             input logic [31:0] exp_x, input logic [31:0] exp_y,
                             input int hold);
        round_done = 1'b1;
        check({tag, "_blk_t0"}, 32'(issue_block), 32'd0);
        tick;
        check({tag, "_blk_t1"}, 32'(issue_block),  32'd1);
        check({tag, "_vld_t1"}, 32'(result_valid), 32'd0);
        round_done = 1'b0;
        tick;
        tick;
        check({tag, "_vld_t3"}, 32'(result_valid), 32'd0);
        tick;
        check({tag, "_vld_t4"}, 32'(result_valid), 32'd1);
        check({tag, "_data"},   32'(result_data),  exp_d);
        check({tag, "_rx"},     32'(result_x),     exp_x);
        check({tag, "_ry"},     32'(result_y),     exp_y);
        for (int i = 0; i < hold; i++) begin
            positioner_x      = 8'd9;
            positioner_y      = 8'd9;
            positioner_select = (i == 3);
            tick;
            check({tag, "_hold_blk"}, 32'(issue_block),  32'd1);
            check({tag, "_hold_vld"}, 32'(result_valid), 32'd1);
            check({tag, "_hold_rx"},  32'(result_x),     exp_x);
        end
        positioner_select = 1'b0;
        result_ready = 1'b1;
        tick;
        result_ready = 1'b0;
        check({tag, "_vld_done"}, 32'(result_valid), 32'd0);
        check({tag, "_blk_done"}, 32'(issue_block),  32'd0);
    endtask

    initial begin
        rst               = 1'b0;
        filter_halfsize   = 2'd1;
        image_depth       = 9'd1;
        positioner_x      = '0;
        positioner_y      = '0;
        positioner_select = 1'b0;
        issue_x           = '0;
        issue_y           = '0;
        issue_data        = '0;
        issue_en          = 1'b0;
        round_done        = 1'b0;
        result_ready      = 1'b0;
        fill_w(18'h100);

        tick; tick; tick;
        check_reset_outputs("reset");
        rst = 1'b1;
        tick;

        // 3x3 window of unit data and weights centred at (5,5), full 11x11 sweep.
        filter_halfsize = 2'd1;
        image_depth     = 9'd1;
        do_select(5, 5);
        for (int y = 0; y <= 10; y++)
            for (int x = 0; x <= 10; x++)
                beat(x, y, 'h100);
        check("t1_waddr", 32'(weight_read_addr), 32'd8);
        check("t1_blk_armed", 32'(issue_block), 32'd0);
        round_end("t1", 32'h900, 32'd5, 32'd5, 0);

        // Corner centre, 5x5 window, negative coordinates never broadcast.
        filter_halfsize = 2'd2;
        do_select(0, 0);
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 4; x++)
                beat(x, y, 'h100);
        round_end("t2", 32'h900, 32'd0, 32'd0, 0);

        // Three channels, only channel 2 weighted by 2.0.
        filter_halfsize = 2'd1;
        image_depth     = 9'd3;
        for (int i = 0; i < 16384; i++) wmem[i] = ((i % 3) == 2) ? 18'h200 : 18'h0;
        do_select(3, 3);
        for (int y = 1; y <= 5; y++)
            for (int x = 1; x <= 5; x++)
                for (int z = 0; z < 3; z++) begin
                    beat(x, y, (z == 2) ? (x * 16 + y) : 'h3000);
                    if (x == 3 && y == 2 && z == 1)
                        check("t3_addr_a", 32'(weight_read_addr), 32'd4);
                    if (x == 4 && y == 4 && z == 2)
                        check("t3_addr_b", 32'(weight_read_addr), 32'd26);
                end
        round_end("t3", 32'h396, 32'd3, 32'd3, 0);

        // Maximum data and weights over 25 taps saturate positive.
        filter_halfsize = 2'd2;
        image_depth     = 9'd1;
        fill_w(18'h1FFFF);
        do_select(2, 2);
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 4; x++)
                beat(x, y, 'h1FFFF);
        round_end("t4", 32'h1FFFF, 32'd2, 32'd2, 0);

        // Single tap summing to -1.0, result held for 10 cycles with a select in FULL.
        filter_halfsize = 2'd0;
        fill_w(18'h100);
        do_select(1, 1);
        beat(1, 1, 'h3FF00);
        beat(2, 1, 'h100);
`ifdef ALLOCATOR_RELU_EN
        round_end("t5", 32'h0, 32'd1, 32'd1, 10);
`else
        round_end("t5", 32'h3FF00, 32'd1, 32'd1, 10);
`endif

        // Reset asserted mid-ARMED returns every output to its reset value.
        filter_halfsize = 2'd1;
        do_select(7, 7);
        beat(8, 8, 'h100);
        check("t6_waddr", 32'(weight_read_addr), 32'd8);
        rst = 1'b0;
        tick;
        check_reset_outputs("t6_rst");
        rst = 1'b1;
        tick;
        round_done = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        round_done = 1'b0;
        check("t6_no_result", 32'(result_valid), 32'd0);
        check("t6_no_block",  32'(issue_block),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
